// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : AES-128 decryption types, GF(2^8) and composite-field arithmetic
// Revision: 1.0
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} dec_state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime: an odd value can only come from a reduced product.
  function automatic logic [7:0] gf_div_x(input logic [7:0] a);
    logic [7:0] t;
    t = a[0] ? (a ^ 8'h1b) : a;
    return {a[0], t[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // GF(2^4) over z^4 + z + 1
  function automatic logic [3:0] gf_mul4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_inv4(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf_mul4(a, a);
    a4 = gf_mul4(a2, a2);
    a8 = gf_mul4(a4, a4);
    return gf_mul4(gf_mul4(a8, a4), a2);
  endfunction

  // The tower constants and basis-change matrices are derived at elaboration.
  function automatic logic [3:0] find_lambda();
    logic [3:0] lam;
    logic       found, has_root;
    lam   = 4'h1;
    found = 1'b0;
    for (int l = 1; l < 16; l++) begin
      has_root = 1'b0;
      for (int t = 0; t < 16; t++)
        if ((gf_mul4(4'(t), 4'(t)) ^ 4'(t) ^ 4'(l)) == 4'h0) has_root = 1'b1;
      if (!has_root && !found) begin
        lam   = 4'(l);
        found = 1'b1;
      end
    end
    return lam;
  endfunction

  function automatic logic [7:0] find_z0();
    logic [7:0] z, x2;
    logic       found;
    z     = 8'h00;
    found = 1'b0;
    for (int x = 2; x < 256; x++) begin
      x2 = gf_mul8(8'(x), 8'(x));
      if (!found && (gf_mul8(x2, x2) ^ 8'(x) ^ 8'h01) == 8'h00) begin
        z     = 8'(x);
        found = 1'b1;
      end
    end
    return z;
  endfunction

  function automatic logic [7:0] find_y0(input logic [3:0] lam, input logic [7:0] z0);
    logic [7:0] lam8, p, y;
    logic       found;
    lam8 = 8'h00;
    p    = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (lam[i]) lam8 = lam8 ^ p;
      p = gf_mul8(p, z0);
    end
    y     = 8'h00;
    found = 1'b0;
    for (int x = 2; x < 256; x++)
      if (!found && (gf_mul8(8'(x), 8'(x)) ^ 8'(x) ^ lam8) == 8'h00) begin
        y     = 8'(x);
        found = 1'b1;
      end
    return y;
  endfunction

  function automatic logic [63:0] build_inv_iso(input logic [7:0] z0, input logic [7:0] y0);
    logic [63:0] cols;
    logic [7:0]  p;
    p = 8'h01;
    for (int i = 0; i < 4; i++) begin
      cols[8*i +: 8]     = p;
      cols[8*i + 32 +: 8] = gf_mul8(p, y0);
      p = gf_mul8(p, z0);
    end
    return cols;
  endfunction

  function automatic logic [7:0] apply_cols(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ cols[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] build_iso(input logic [63:0] inv_cols);
    logic [63:0] cols;
    cols = 64'h0;
    for (int j = 0; j < 8; j++)
      for (int c = 0; c < 256; c++)
        if (apply_cols(inv_cols, 8'(c)) == (8'h01 << j)) cols[8*j +: 8] = 8'(c);
    return cols;
  endfunction

  localparam logic [3:0]  GF4_LAMBDA   = find_lambda();
  localparam logic [7:0]  GF8_Z0       = find_z0();
  localparam logic [7:0]  GF8_Y0       = find_y0(GF4_LAMBDA, GF8_Z0);
  localparam logic [63:0] INV_ISO_COLS = build_inv_iso(GF8_Z0, GF8_Y0);
  localparam logic [63:0] ISO_COLS     = build_iso(INV_ISO_COLS);

  function automatic logic [7:0] isomorph(input logic [7:0] x);
    return apply_cols(ISO_COLS, x);
  endfunction

  function automatic logic [7:0] inv_isomorph(input logic [7:0] x);
    return apply_cols(INV_ISO_COLS, x);
  endfunction

  // (hY + l)^-1 with Y^2 = Y + lambda; zero maps to zero.
  function automatic logic [7:0] comp_inverse(input logic [7:0] x);
    logic [3:0] h, l, d, di;
    h  = x[7:4];
    l  = x[3:0];
    d  = gf_mul4(gf_mul4(h, h), GF4_LAMBDA) ^ gf_mul4(h, l) ^ gf_mul4(l, l);
    di = gf_inv4(d);
    return {gf_mul4(h, di), gf_mul4(h ^ l, di)};
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a, x2, x4, x8;
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a     = s[127-32*c-8*r -: 8];
        x2    = xtime(a);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a;
        mb[r] = x8 ^ x2 ^ a;
        md[r] = x8 ^ x4 ^ a;
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[119-32*c -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[111-32*c -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[103-32*c -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_dual.sv
`default_nettype none
// ============================================================================
// aes_sbox_dual : combinational forward/inverse AES S-box via composite field
// Revision: 1.0
// ============================================================================
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] pre, recip;

  assign pre      = inv ? inv_affine(in_byte) : in_byte;
  assign recip    = inv_isomorph(comp_inverse(isomorph(pre)));
  assign out_byte = inv ? recip : affine(recip);

endmodule
`default_nettype wire

// File: rtl/aes_dec_iter.sv
`default_nettype none
// ============================================================================
// aes_dec_iter : iterative AES-128 decryptor, one round per cycle, keys rolled back
// Revision: 1.0
// ============================================================================
module aes_dec_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  dec_state     fsm, fsm_nxt;
  logic [127:0] blk, rkey;
  logic [7:0]   rcon;
  logic [3:0]   round;

  logic [127:0] shifted, subbed, prev_key, added, mixed;
  logic [31:0]  w0, w1, w2, w3, w0n, w1n, w2n, w3n, rot_w, sub_w;

  assign shifted = inv_shift_rows(blk);

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox_dual u_sbox (
      .inv      (1'b1),
      .in_byte  (shifted[127-8*i -: 8]),
      .out_byte (subbed[127-8*i -: 8])
    );
  end

  // Step the schedule back one round: recover w3..w1 by XOR, then w0 via SubWord.
  assign {w0, w1, w2, w3} = rkey;
  assign w3n   = w3 ^ w2;
  assign w2n   = w2 ^ w1;
  assign w1n   = w1 ^ w0;
  assign rot_w = {w3n[23:0], w3n[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox_dual u_sbox (
      .inv      (1'b0),
      .in_byte  (rot_w[31-8*j -: 8]),
      .out_byte (sub_w[31-8*j -: 8])
    );
  end

  assign w0n      = w0 ^ sub_w ^ {rcon, 24'h0};
  assign prev_key = {w0n, w1n, w2n, w3n};
  assign added    = subbed ^ prev_key;
  assign mixed    = inv_mix_columns(added);
  assign out_data = blk;

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = RUN;
      end
      RUN: begin
        if (round == 4'd0) fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk   <= 128'h0;
      rkey  <= 128'h0;
      rcon  <= 8'h00;
      round <= 4'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            blk   <= in_data ^ in_key;
            rkey  <= in_key;
            rcon  <= 8'h36;
            round <= 4'd9;
          end
        end
        RUN: begin
          blk  <= (round == 4'd0) ? added : mixed;
          rkey <= prev_key;
          rcon <= gf_div_x(rcon);
          if (round != 4'd0) round <= round - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_iter.sv
`default_nettype none
// ============================================================================
// tb_aes_dec_iter : known-answer, handshake corner cases and random vs. model
// Revision: 1.0
// ============================================================================
module tb_aes_dec_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, in_key, out_data;

  always #5 clk = ~clk;

  aes_dec_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  vec_t       vecs [2];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box tables from brute-force inverses and the bitwise affine definition.
  task automatic build_tables();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  // Full key schedule recovered backwards from round key 10, then textbook inverse cipher.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input logic [127:0] k10);
    logic [31:0]  w [44];
    logic [7:0]   rc [11];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [127:0] o;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int j = 2; j < 11; j++) rc[j] = gmul(rc[j-1], 8'h02);
    for (int j = 0; j < 4; j++) w[40+j] = k10[127-32*j -: 32];
    for (int i = 39; i >= 0; i--) begin
      tmp = w[i+3];
      if ((i % 4) == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc[(i+4)/4], 24'h0};
      end
      w[i] = w[i+4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = ct[127-8*(4*c+r) -: 8];
    for (int rnd = 10; rnd >= 0; rnd--) begin
      if (rnd != 10) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) t[r][c] = s[r][(c-r+4)%4];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r][c] = isb[t[r][c]];
      end
      for (int c = 0; c < 4; c++) begin
        tmp = w[4*rnd+c];
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ tmp[31-8*r -: 8];
      end
      if (rnd != 10 && rnd != 0)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r][c] = s[r][c];
          s[0][c] = gmul(t[0][c],8'h0e) ^ gmul(t[1][c],8'h0b) ^ gmul(t[2][c],8'h0d) ^ gmul(t[3][c],8'h09);
          s[1][c] = gmul(t[0][c],8'h09) ^ gmul(t[1][c],8'h0e) ^ gmul(t[2][c],8'h0b) ^ gmul(t[3][c],8'h0d);
          s[2][c] = gmul(t[0][c],8'h0d) ^ gmul(t[1][c],8'h09) ^ gmul(t[2][c],8'h0e) ^ gmul(t[3][c],8'h0b);
          s[3][c] = gmul(t[0][c],8'h0b) ^ gmul(t[1][c],8'h0d) ^ gmul(t[2][c],8'h09) ^ gmul(t[3][c],8'h0e);
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_job(input logic [127:0] d, input logic [127:0] k);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    while (in_ready !== 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("accept_wait", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts rising edges with the accept edge as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [127:0] snap, res, exp_pt, d, k;
  logic         ok, got, r;
  int           lat, g;

  initial begin
    build_tables();
    vecs[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'h3243f6a8885a308d313198a2e0370734};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_data  = vecs[0].data;
    in_key   = vecs[0].key;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);

    for (int i = 0; i < 2; i++) begin
      start_job(vecs[i].data, vecs[i].key);
      wait_out(lat);
      chk($sformatf("kat%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("kat%0d_latency", i), 128'(lat), 128'd11);
      release_out();
      chk($sformatf("kat%0d_idle_after", i), {126'd0, in_ready, out_valid}, 128'd2);
    end

    // Backpressure: result held for 20 cycles.
    start_job(vecs[0].data, vecs[0].key);
    wait_out(lat);
    snap = out_data;
    ok   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", 128'(ok), 128'd1);
    chk("bp_data", out_data, vecs[0].exp);
    release_out();
    chk("bp_release", {126'd0, in_ready, out_valid}, 128'd2);

    // Overrun: second job held on in_valid throughout the first; out_ready pulsed in RUN.
    start_job(vecs[0].data, vecs[0].key);
    in_valid = 1'b1;
    in_data  = vecs[1].data;
    in_key   = vecs[1].key;
    ok  = 1'b1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      out_ready = (lat < 8);
      if (in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk("ovr_busy", 128'(ok), 128'd1);
    chk("ovr_first_latency", 128'(lat), 128'd11);
    chk("ovr_first_data", out_data, vecs[0].exp);
    release_out();
    chk("ovr_idle", {126'd0, in_ready, out_valid}, 128'd2);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("ovr_second_latency", 128'(lat), 128'd11);
    chk("ovr_second_data", out_data, vecs[1].exp);
    release_out();

    // Reset while the round counter reads 5.
    start_job(vecs[0].data, vecs[0].key);
    repeat (4) @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("abort_idle", {126'd0, in_ready, out_valid}, 128'd2);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("abort_silent", 128'(ok), 128'd1);
    start_job(vecs[0].data, vecs[0].key);
    wait_out(lat);
    chk("abort_rerun_data", out_data, vecs[0].exp);
    chk("abort_rerun_latency", 128'(lat), 128'd11);
    release_out();

    // Random jobs with random consumer stalls.
    for (int n = 0; n < 100; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d      = {$urandom, $urandom, $urandom, $urandom};
      k      = {$urandom, $urandom, $urandom, $urandom};
      exp_pt = ref_decrypt(d, k);
      start_job(d, k);
      got = 1'b0;
      g   = 0;
      res = '0;
      while (!got && g < 80) begin
        @(negedge clk);
        g++;
        r         = 1'($urandom_range(0, 1));
        out_ready = r;
        if (out_valid === 1'b1 && r) begin
          res = out_data;
          got = 1'b1;
        end
      end
      chk($sformatf("rnd%0d_data", n), res, exp_pt);
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("rnd%0d_no_dup", n), 128'(out_valid), 128'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
